control_seq: RTL and testbench

Parametrised multi-cycle instruction sequencer for the CPU core. It steps each instruction through fetch, register load, ALU or memory access, register store and PC advance, driving one-hot phase strobes to the datapath. Compared with the fixed single-cycle-per-phase controller, it adds:
- memory wait states via a ready handshake, with a timeout;
- halt and single-step debug control;
- a sticky fault state for illegal opcodes and memory timeouts;
- a retired-instruction counter.

---
 rtl/control_seq.sv | 123 ++++++++++++
 tb/tb_control_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// control_seq: multi-cycle instruction sequencer with memory wait states, halt/step debug, sticky fault and retired count
module control_seq #(
  parameter int NIB_SIZE = 4,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NIB_SIZE-1:0] opcode,
  input  logic                isaluop,
  input  logic                mem_ready,
  input  logic                halt_req,
  input  logic                step_mode,
  input  logic                step,
  input  logic                fault_clr,
  output logic                do_fetch,
  output logic                do_regload,
  output logic                do_aluop,
  output logic                do_memload,
  output logic                do_memstore,
  output logic                do_regstore,
  output logic                do_next,
  output logic                do_reset,
  output logic                do_wait,
  output logic                halted,
  output logic                fault,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    instr_count,
  output logic [1:0]          fault_cause
);
  localparam logic [NIB_SIZE-1:0] OP_LOAD   = NIB_SIZE'(1);
  localparam logic [NIB_SIZE-1:0] OP_STORE  = NIB_SIZE'(2);
  localparam logic [NIB_SIZE-1:0] OP_IN     = NIB_SIZE'(3);
  localparam logic [NIB_SIZE-1:0] OP_OUT    = NIB_SIZE'(4);
  localparam logic [NIB_SIZE-1:0] OP_LOADLO = NIB_SIZE'(5);
  localparam logic [NIB_SIZE-1:0] OP_LOADHI = NIB_SIZE'(6);
  localparam logic [NIB_SIZE-1:0] OP_JMP    = NIB_SIZE'(7);
  localparam logic [NIB_SIZE-1:0] OP_BR     = NIB_SIZE'(8);
  localparam int WW = $clog2(WAIT_MAX + 1);
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_REGLOAD  = 4'd2,
    S_ALUOP    = 4'd3,
    S_LOAD     = 4'd4,
    S_STORE    = 4'd5,
    S_REGSTORE = 4'd6,
    S_NEXT     = 4'd7,
    S_HALT     = 4'd8,
    S_FAULT    = 4'd9
  } state_t;
  state_t            r_state;
  logic [WW-1:0]     r_wait;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_cause;
  logic              w_mem;
  logic              w_hold;
  logic              w_tout;
  assign w_mem  = r_state inside {S_FETCH, S_LOAD, S_STORE};
  assign w_hold = w_mem & ~mem_ready;
  assign w_tout = w_hold && (r_wait == WW'(WAIT_MAX));
  // Sequencer state, wait counter (self-zeroing whenever a memory phase is not holding), retired count and fault cause
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_wait  <= '0;
      r_count <= '0;
      r_cause <= 2'd0;
    end else begin
      r_wait <= w_hold ? r_wait + 1'b1 : '0;
      if (r_state == S_NEXT) r_count <= r_count + 1'b1;
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH:
          if (mem_ready) r_state <= S_REGLOAD;
          else if (w_tout) begin
            r_state <= S_FAULT;
            r_cause <= 2'd2;
          end
        S_REGLOAD:
          if (isaluop) r_state <= S_ALUOP;
          else if (opcode == OP_LOAD || opcode == OP_IN) r_state <= S_LOAD;
          else if (opcode == OP_STORE || opcode == OP_OUT) r_state <= S_STORE;
          else if (opcode == OP_LOADLO || opcode == OP_LOADHI) r_state <= S_REGSTORE;
          else if (opcode == OP_JMP || opcode == OP_BR) r_state <= S_NEXT;
          else begin
            r_state <= S_FAULT;
            r_cause <= 2'd1;
          end
        S_ALUOP: r_state <= S_REGSTORE;
        S_LOAD, S_STORE:
          if (mem_ready) r_state <= (r_state == S_LOAD) ? S_REGSTORE : S_NEXT;
          else if (w_tout) begin
            r_state <= S_FAULT;
            r_cause <= 2'd3;
          end
        S_REGSTORE: r_state <= S_NEXT;
        S_NEXT: r_state <= (halt_req || step_mode) ? S_HALT : S_FETCH;
        S_HALT: if (!halt_req && (!step_mode || step)) r_state <= S_FETCH;
        S_FAULT:
          if (fault_clr) begin
            r_state <= S_RESET;
            r_cause <= 2'd0;
          end
        default: r_state <= S_RESET;
      endcase
    end
  end
  assign do_reset    = r_state == S_RESET;
  assign do_fetch    = r_state == S_FETCH;
  assign do_regload  = r_state == S_REGLOAD;
  assign do_aluop    = r_state == S_ALUOP;
  assign do_memload  = r_state == S_LOAD;
  assign do_memstore = r_state == S_STORE;
  assign do_regstore = r_state == S_REGSTORE;
  assign do_next     = r_state == S_NEXT;
  assign halted      = r_state == S_HALT;
  assign fault       = r_state == S_FAULT;
  assign do_wait     = w_hold;
  assign state       = r_state;
  assign instr_count = r_count;
  assign fault_cause = r_cause;
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: scenario-driven bench with expected-state scoreboard for control_seq
module tb_control_seq;
  localparam logic [3:0] OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_IN = 4'h3, OP_OUT = 4'h4;
  localparam logic [3:0] OP_LOADLO = 4'h5, OP_LOADHI = 4'h6, OP_JMP = 4'h7, OP_BR = 4'h8, OP_BAD = 4'hD;
  logic clk = 0, reset = 1, isaluop = 0, mem_ready = 1, halt_req = 0, step_mode = 0, step = 0, fault_clr = 0;
  logic [3:0] opcode = 4'h0;
  logic do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next, do_reset, do_wait, halted, fault;
  logic [3:0] state;
  logic [15:0] instr_count;
  logic [1:0] fault_cause;
  logic d2_fetch, d2_regload, d2_aluop, d2_memload, d2_memstore, d2_regstore, d2_next, d2_reset, d2_wait, d2_halted, d2_fault;
  logic [3:0] d2_state;
  logic [1:0] d2_count;
  logic [1:0] d2_cause;
  int n_chk = 0, n_fail = 0;
  logic [3:0] q[$];
  logic [3:0] e;
  control_seq u_dut (
    .clk(clk), .reset(reset), .opcode(opcode), .isaluop(isaluop), .mem_ready(mem_ready),
    .halt_req(halt_req), .step_mode(step_mode), .step(step), .fault_clr(fault_clr),
    .do_fetch(do_fetch), .do_regload(do_regload), .do_aluop(do_aluop), .do_memload(do_memload),
    .do_memstore(do_memstore), .do_regstore(do_regstore), .do_next(do_next), .do_reset(do_reset),
    .do_wait(do_wait), .halted(halted), .fault(fault), .state(state),
    .instr_count(instr_count), .fault_cause(fault_cause)
  );
  control_seq #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .isaluop(isaluop), .mem_ready(mem_ready),
    .halt_req(halt_req), .step_mode(step_mode), .step(step), .fault_clr(fault_clr),
    .do_fetch(d2_fetch), .do_regload(d2_regload), .do_aluop(d2_aluop), .do_memload(d2_memload),
    .do_memstore(d2_memstore), .do_regstore(d2_regstore), .do_next(d2_next), .do_reset(d2_reset),
    .do_wait(d2_wait), .halted(d2_halted), .fault(d2_fault), .state(d2_state),
    .instr_count(d2_count), .fault_cause(d2_cause)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go_reset;
    reset = 1;
    tick;
    reset = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    mem_ready = 0;
    tick;
    tick;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_chk++;
    if ({do_reset, do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next, do_wait, halted, fault} !== 11'b100_0000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 10000000000",
               {do_reset, do_fetch, do_regload, do_aluop, do_memload, do_memstore, do_regstore, do_next, do_wait, halted, fault});
    end
    n_chk++; if (instr_count !== 16'd0 || fault_cause !== 2'd0) begin n_fail++; $display("FAIL reset_regs: got count %0d cause %0d expected 0 0", instr_count, fault_cause); end
    reset = 0;
    mem_ready = 1;
  endtask
  task automatic test_alu;
    go_reset;
    isaluop = 1;
    mem_ready = 1;
    q = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd1};
    while (q.size() > 0) begin
      tick;
      e = q.pop_front();
      n_chk++; if (state !== e) begin n_fail++; $display("FAIL alu_seq: got %0d expected %0d", state, e); end
    end
    n_chk++; if (instr_count !== 16'd1) begin n_fail++; $display("FAIL alu_count: got %0d expected 1", instr_count); end
    isaluop = 0;
  endtask
  task automatic test_load_wait;
    logic mr_pat [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_s [9] = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4, 4'd6, 4'd7, 4'd1};
    int n_wait, n_load, n_cyc;
    n_wait = 0; n_load = 0; n_cyc = 0;
    go_reset;
    opcode = OP_LOAD;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr_pat[i];
      q.push_back(exp_s[i]);
      #1;
      if (do_wait) n_wait++;
      if (state == 4'd4) n_load++;
      if (state != 4'd0) n_cyc++;
      tick;
      e = q.pop_front();
      n_chk++; if (state !== e) begin n_fail++; $display("FAIL load_seq[%0d]: got %0d expected %0d", i, state, e); end
    end
    n_chk++; if (n_load !== 4) begin n_fail++; $display("FAIL load_len: got %0d expected 4", n_load); end
    n_chk++; if (n_wait !== 3) begin n_fail++; $display("FAIL load_do_wait: got %0d expected 3", n_wait); end
    n_chk++; if (n_cyc !== 8) begin n_fail++; $display("FAIL load_instr_cycles: got %0d expected 8", n_cyc); end
    mem_ready = 1;
  endtask
  task automatic test_timeout;
    int n;
    go_reset;
    mem_ready = 0;
    tick;
    n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL tmo_fetch_entry: got %0d expected 1", state); end
    n = 0;
    while (state !== 4'd9 && n < 40) begin tick; n++; end
    n_chk++; if (n !== 16) begin n_fail++; $display("FAIL tmo_fetch_cycles: got %0d expected 16", n); end
    n_chk++; if (fault_cause !== 2'd2 || fault !== 1'b1) begin n_fail++; $display("FAIL tmo_fetch_cause: got cause %0d fault %0d expected 2 1", fault_cause, fault); end
    tick;
    n_chk++; if (state !== 4'd9) begin n_fail++; $display("FAIL fault_sticky: got %0d expected 9", state); end
    fault_clr = 1;
    tick;
    fault_clr = 0;
    n_chk++; if (state !== 4'd0 || fault_cause !== 2'd0) begin n_fail++; $display("FAIL fault_clr: got state %0d cause %0d expected 0 0", state, fault_cause); end
    mem_ready = 1;
    tick;
    n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL fault_clr_fetch: got %0d expected 1", state); end
    go_reset;
    opcode = OP_LOAD;
    repeat (3) tick;
    mem_ready = 0;
    repeat (15) tick;
    n_chk++; if (state !== 4'd4) begin n_fail++; $display("FAIL load_hold15: got %0d expected 4", state); end
    mem_ready = 1;
    tick;
    n_chk++; if (state !== 4'd6 || fault_cause !== 2'd0) begin n_fail++; $display("FAIL ready_wins: got state %0d cause %0d expected 6 0", state, fault_cause); end
    go_reset;
    opcode = OP_STORE;
    repeat (3) tick;
    n_chk++; if (state !== 4'd5) begin n_fail++; $display("FAIL store_entry: got %0d expected 5", state); end
    mem_ready = 0;
    repeat (15) tick;
    n_chk++; if (state !== 4'd5) begin n_fail++; $display("FAIL store_hold15: got %0d expected 5", state); end
    tick;
    n_chk++; if (state !== 4'd9 || fault_cause !== 2'd3) begin n_fail++; $display("FAIL store_timeout: got state %0d cause %0d expected 9 3", state, fault_cause); end
    reset = 1;
    tick;
    reset = 0;
    n_chk++; if (state !== 4'd0 || fault_cause !== 2'd0) begin n_fail++; $display("FAIL reset_in_fault: got state %0d cause %0d expected 0 0", state, fault_cause); end
    mem_ready = 1;
  endtask
  task automatic test_illegal;
    go_reset;
    opcode = OP_BAD;
    mem_ready = 1;
    tick;
    tick;
    n_chk++; if (state !== 4'd2) begin n_fail++; $display("FAIL illegal_regload: got %0d expected 2", state); end
    tick;
    n_chk++; if (state !== 4'd9 || fault !== 1'b1 || fault_cause !== 2'd1) begin n_fail++; $display("FAIL illegal_fault: got state %0d fault %0d cause %0d expected 9 1 1", state, fault, fault_cause); end
  endtask
  task automatic test_step;
    int n;
    go_reset;
    opcode = OP_JMP;
    mem_ready = 1;
    step_mode = 1;
    q = '{4'd1, 4'd2, 4'd7, 4'd8};
    while (q.size() > 0) begin
      tick;
      e = q.pop_front();
      n_chk++; if (state !== e) begin n_fail++; $display("FAIL step_first: got %0d expected %0d", state, e); end
    end
    n_chk++; if (halted !== 1'b1 || instr_count !== 16'd1) begin n_fail++; $display("FAIL step_halted: got halted %0d count %0d expected 1 1", halted, instr_count); end
    tick;
    tick;
    n_chk++; if (state !== 4'd8) begin n_fail++; $display("FAIL step_wait: got %0d expected 8", state); end
    for (int k = 0; k < 3; k++) begin
      step = 1;
      tick;
      step = 0;
      n = 0;
      for (int c = 0; c < 20 && state !== 4'd8; c++) begin n++; tick; end
      n_chk++; if (n !== 3) begin n_fail++; $display("FAIL step_cycles[%0d]: got %0d expected 3", k, n); end
      n_chk++; if (instr_count !== 16'(k + 2)) begin n_fail++; $display("FAIL step_count[%0d]: got %0d expected %0d", k, instr_count, k + 2); end
    end
    halt_req = 1;
    step = 1;
    tick;
    step = 0;
    n_chk++; if (state !== 4'd8) begin n_fail++; $display("FAIL step_vs_halt: got %0d expected 8", state); end
    halt_req = 0;
    step_mode = 0;
    tick;
    n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL halt_release: got %0d expected 1", state); end
  endtask
  task automatic test_halt_midinstr;
    go_reset;
    isaluop = 1;
    mem_ready = 1;
    tick;
    tick;
    halt_req = 1;
    q = '{4'd3, 4'd6, 4'd7, 4'd8, 4'd8};
    while (q.size() > 0) begin
      tick;
      e = q.pop_front();
      n_chk++; if (state !== e) begin n_fail++; $display("FAIL halt_mid: got %0d expected %0d", state, e); end
    end
    halt_req = 0;
    tick;
    n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL halt_mid_release: got %0d expected 1", state); end
    isaluop = 0;
  endtask
  task automatic test_back_to_back;
    logic alu_t [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] op_t [8] = '{OP_JMP, OP_LOADLO, OP_BR, OP_OUT, OP_IN, OP_LOADHI, OP_JMP, OP_STORE};
    int cyc_t [8] = '{5, 4, 3, 4, 5, 4, 3, 4};
    int n;
    go_reset;
    mem_ready = 1;
    tick;
    for (int i = 0; i < 8; i++) begin
      isaluop = alu_t[i];
      opcode = op_t[i];
      n = 0;
      do begin tick; n++; end while (state !== 4'd1 && n < 20);
      n_chk++; if (n !== cyc_t[i]) begin n_fail++; $display("FAIL b2b_cycles[%0d]: got %0d expected %0d", i, n, cyc_t[i]); end
    end
    isaluop = 0;
    n_chk++; if (instr_count !== 16'd8 || d2_count !== 2'd0) begin n_fail++; $display("FAIL b2b_count: got %0d/%0d expected 8/0", instr_count, d2_count); end
  endtask
  task automatic test_reset_mid_store;
    go_reset;
    opcode = OP_STORE;
    mem_ready = 1;
    tick;
    repeat (16) tick;
    n_chk++; if (instr_count !== 16'd4 || d2_count !== 2'd0) begin n_fail++; $display("FAIL wrap4: got %0d/%0d expected 4/0", instr_count, d2_count); end
    repeat (4) tick;
    n_chk++; if (instr_count !== 16'd5 || d2_count !== 2'd1) begin n_fail++; $display("FAIL count5: got %0d/%0d expected 5/1", instr_count, d2_count); end
    tick;
    tick;
    mem_ready = 0;
    tick;
    tick;
    n_chk++; if (state !== 4'd5 || do_wait !== 1'b1) begin n_fail++; $display("FAIL store_wait: got state %0d do_wait %0d expected 5 1", state, do_wait); end
    reset = 1;
    tick;
    reset = 0;
    n_chk++; if (state !== 4'd0 || instr_count !== 16'd0 || do_reset !== 1'b1 || d2_count !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_store: got state %0d count %0d do_reset %0d expected 0 0 1", state, instr_count, do_reset);
    end
    n_chk++; if (do_wait !== 1'b0) begin n_fail++; $display("FAIL reset_do_wait: got %0d expected 0", do_wait); end
    mem_ready = 1;
  endtask
  initial begin
    test_reset;
    test_alu;
    test_load_wait;
    test_timeout;
    test_illegal;
    test_step;
    test_halt_midinstr;
    test_back_to_back;
    test_reset_mid_store;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
